// File: rtl/bp_pkg.sv
// ----------------------------------------------------------------------------
// bp_pkg
//   Shared types and helpers for the dynamic branch predictor.
//   - Table geometry defaults (PC / tag / counter widths).
//   - bp_entry_t  : one BTB entry {valid, tag, target, ctr}.
//   - CTR_WEAK_T / CTR_WEAK_NT : counter allocate / reset values.
//   - sat_step()  : saturating up/down step of a direction counter.
//   The BTB storage is built from bp_entry_t, so its field widths come from
//   this package; change table geometry here rather than only on the top.
// ----------------------------------------------------------------------------
package bp_pkg;

    localparam int BP_PC_WIDTH  = 32;
    localparam int BP_ENTRY_BIT = 6;
    localparam int BP_TAG_BIT   = 8;
    localparam int BP_CTR_BIT   = 2;
    localparam int BP_CNT_WIDTH = 32;

    typedef logic [BP_CTR_BIT-1:0] ctr_t;

    typedef struct packed {
        logic                   valid;
        logic [BP_TAG_BIT-1:0]  tag;
        logic [BP_PC_WIDTH-1:0] target;
        ctr_t                   ctr;
    } bp_entry_t;

    // MSB set, rest clear: lowest "taken" value.
    localparam ctr_t CTR_WEAK_T  = ctr_t'(1) << (BP_CTR_BIT - 1);
    // One below weakly taken: highest "not taken" value.
    localparam ctr_t CTR_WEAK_NT = CTR_WEAK_T - ctr_t'(1);

    // Step toward taken (up=1) or not taken (up=0), holding at the rails.
    function automatic ctr_t sat_step(input ctr_t ctr, input logic up);
        ctr_t nxt;
        nxt = ctr;
        if (up && (ctr != '1))
            nxt = ctr + ctr_t'(1);
        else if (!up && (ctr != '0))
            nxt = ctr - ctr_t'(1);
        return nxt;
    endfunction

endpackage

// File: rtl/bp_sat_ctr.sv
// ----------------------------------------------------------------------------
// bp_sat_ctr
//   Combinational saturating up/down counter step, used as the shared
//   counter-update datapath of the predictor (one instance, fed by whichever
//   table entry the resolving branch addresses).
//   Ports:
//     ctr_i  in  current counter value
//     up_i   in  1 = branch taken (count up), 0 = not taken (count down)
//     ctr_o  out next counter value, clamped at 0 and all-ones
// ----------------------------------------------------------------------------
module bp_sat_ctr
    import bp_pkg::*;
(
    input  logic [BP_CTR_BIT-1:0] ctr_i,
    input  logic                  up_i,
    output logic [BP_CTR_BIT-1:0] ctr_o
);

    assign ctr_o = sat_step(ctr_i, up_i);

endmodule

// File: rtl/branch_predictor.sv
// ----------------------------------------------------------------------------
// branch_predictor
//   Direct-mapped BTB with 2-bit saturating direction counters. Lookup on the
//   fetch PC is purely combinational; EX feeds back resolved conditional
//   branches, which update the table on the next rising clk edge and raise a
//   combinational mispredict in the same cycle.
//
//   Optional build macro: BP_GSHARE_EN
//     Direction comes from a separate pattern table indexed by
//     (pc index XOR global history). Adds ports pred_ghr / upd_ghr. The BTB
//     then supplies only hit and target; its ctr field is left untouched.
//
//   Ports:
//     clk, reset (async, active low), flush (sync invalidate of all entries)
//     pc                      : fetch PC
//     pred_hit/taken/target   : lookup result (target = pc+4 if not taken)
//     upd_valid/pc/taken/target, upd_pred_taken/target : EX resolution
//     mispredict              : combinational redirect request
//     branch_cnt, mispredict_cnt : wrapping statistics
//     pred_ghr, upd_ghr       : (BP_GSHARE_EN only) history at lookup / update
// ----------------------------------------------------------------------------
module branch_predictor
    import bp_pkg::*;
#(
    parameter int PC_WIDTH  = BP_PC_WIDTH,
    parameter int ENTRY_BIT = BP_ENTRY_BIT,
    parameter int TAG_BIT   = BP_TAG_BIT,
    parameter int CTR_BIT   = BP_CTR_BIT,
    parameter int CNT_WIDTH = BP_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic [PC_WIDTH-1:0]  pc,
    output logic                 pred_hit,
    output logic                 pred_taken,
    output logic [PC_WIDTH-1:0]  pred_target,
    input  logic                 upd_valid,
    input  logic [PC_WIDTH-1:0]  upd_pc,
    input  logic                 upd_taken,
    input  logic [PC_WIDTH-1:0]  upd_target,
    input  logic                 upd_pred_taken,
    input  logic [PC_WIDTH-1:0]  upd_pred_target,
    output logic                 mispredict,
    output logic [CNT_WIDTH-1:0] branch_cnt,
    output logic [CNT_WIDTH-1:0] mispredict_cnt
`ifdef BP_GSHARE_EN
    ,
    output logic [ENTRY_BIT-1:0] pred_ghr,
    input  logic [ENTRY_BIT-1:0] upd_ghr
`endif
);

    localparam int ENTRIES = 1 << ENTRY_BIT;
    localparam int TAG_LO  = ENTRY_BIT + 2;
    localparam int TAG_HI  = ENTRY_BIT + TAG_BIT + 1;

    bp_entry_t btb_q [ENTRIES];
    bp_entry_t btb_d [ENTRIES];

    logic [CNT_WIDTH-1:0] branch_cnt_q, branch_cnt_d;
    logic [CNT_WIDTH-1:0] mispredict_cnt_q, mispredict_cnt_d;

    logic [ENTRY_BIT-1:0] idx, upd_idx;
    logic [TAG_BIT-1:0]   tag, upd_tag;
    bp_entry_t            look_ent, upd_ent;
    logic                 upd_hit;
    logic                 look_dir;
    logic [CTR_BIT-1:0]   upd_ctr_cur, upd_ctr_nxt;

    assign idx      = pc[ENTRY_BIT+1:2];
    assign tag      = pc[TAG_HI:TAG_LO];
    assign upd_idx  = upd_pc[ENTRY_BIT+1:2];
    assign upd_tag  = upd_pc[TAG_HI:TAG_LO];

    // Only the index and tag fields of either PC participate.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{pc[1:0], pc[PC_WIDTH-1:TAG_HI+1],
                              upd_pc[1:0], upd_pc[PC_WIDTH-1:TAG_HI+1]};

    // ---------------- lookup (reads registered state only: no bypass) -------
    assign look_ent    = btb_q[idx];
    assign pred_hit    = look_ent.valid && (look_ent.tag == tag);
    assign pred_taken  = pred_hit && look_dir;
    assign pred_target = pred_taken ? look_ent.target : pc + PC_WIDTH'(4);

    // ---------------- resolution -------------------------------------------
    assign mispredict = upd_valid &&
                        ((upd_pred_taken != upd_taken) ||
                         (upd_taken && (upd_pred_target != upd_target)));

    assign upd_ent = btb_q[upd_idx];
    assign upd_hit = upd_ent.valid && (upd_ent.tag == upd_tag);

    bp_sat_ctr u_sat_ctr (
        .ctr_i (upd_ctr_cur),
        .up_i  (upd_taken),
        .ctr_o (upd_ctr_nxt)
    );

`ifdef BP_GSHARE_EN
    logic [CTR_BIT-1:0]   pht_q [ENTRIES];
    logic [CTR_BIT-1:0]   pht_d [ENTRIES];
    logic [ENTRY_BIT-1:0] ghr_q, ghr_d;
    logic [ENTRY_BIT-1:0] pht_upd_idx;

    assign pred_ghr    = ghr_q;
    assign look_dir    = pht_q[idx ^ ghr_q][CTR_BIT-1];
    // Update uses the history the branch was predicted with, not the live one.
    assign pht_upd_idx = upd_idx ^ upd_ghr;
    assign upd_ctr_cur = pht_q[pht_upd_idx];

    always_comb begin
        pht_d = pht_q;
        ghr_d = ghr_q;
        if (upd_valid) begin
            ghr_d = {ghr_q[ENTRY_BIT-2:0], upd_taken};
            if (!flush)
                pht_d[pht_upd_idx] = upd_ctr_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ghr_q <= '0;
            for (int i = 0; i < ENTRIES; i++)
                pht_q[i] <= CTR_WEAK_NT;
        end else begin
            ghr_q <= ghr_d;
            pht_q <= pht_d;
        end
    end
`else
    assign look_dir    = look_ent.ctr[CTR_BIT-1];
    assign upd_ctr_cur = upd_ent.ctr;
`endif

    // ---------------- BTB next state ---------------------------------------
    always_comb begin
        btb_d = btb_q;
        if (flush) begin
            // Flush wins over a same-cycle update.
            for (int i = 0; i < ENTRIES; i++)
                btb_d[i].valid = 1'b0;
        end else if (upd_valid) begin
            if (upd_hit) begin
`ifndef BP_GSHARE_EN
                btb_d[upd_idx].ctr = upd_ctr_nxt;
`endif
                if (upd_taken)
                    btb_d[upd_idx].target = upd_target;
            end else if (upd_taken) begin
                // Allocate over whatever occupies the slot.
                btb_d[upd_idx].valid  = 1'b1;
                btb_d[upd_idx].tag    = upd_tag;
                btb_d[upd_idx].target = upd_target;
                btb_d[upd_idx].ctr    = CTR_WEAK_T;
            end
        end
    end

    // ---------------- statistics -------------------------------------------
    always_comb begin
        branch_cnt_d     = branch_cnt_q;
        mispredict_cnt_d = mispredict_cnt_q;
        if (upd_valid)
            branch_cnt_d = branch_cnt_q + CNT_WIDTH'(1);
        if (mispredict)
            mispredict_cnt_d = mispredict_cnt_q + CNT_WIDTH'(1);
    end

    assign branch_cnt     = branch_cnt_q;
    assign mispredict_cnt = mispredict_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                btb_q[i].valid  <= 1'b0;
                btb_q[i].tag    <= '0;
                btb_q[i].target <= '0;
                btb_q[i].ctr    <= CTR_WEAK_NT;
            end
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
        end else begin
            btb_q            <= btb_d;
            branch_cnt_q     <= branch_cnt_d;
            mispredict_cnt_q <= mispredict_cnt_d;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        reset, flush;
    logic [31:0] pc;
    logic        pred_hit, pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid, upd_taken, upd_pred_taken;
    logic [31:0] upd_pc, upd_target, upd_pred_target;
    logic        mispredict;
    logic [31:0] branch_cnt, mispredict_cnt;
`ifdef BP_GSHARE_EN
    logic [5:0]  pred_ghr;
    logic [5:0]  upd_ghr = '0;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    branch_predictor dut (
        .clk             (clk),
        .reset           (reset),
        .flush           (flush),
        .pc              (pc),
        .pred_hit        (pred_hit),
        .pred_taken      (pred_taken),
        .pred_target     (pred_target),
        .upd_valid       (upd_valid),
        .upd_pc          (upd_pc),
        .upd_taken       (upd_taken),
        .upd_target      (upd_target),
        .upd_pred_taken  (upd_pred_taken),
        .upd_pred_target (upd_pred_target),
        .mispredict      (mispredict),
        .branch_cnt      (branch_cnt),
        .mispredict_cnt  (mispredict_cnt)
`ifdef BP_GSHARE_EN
        ,
        .pred_ghr        (pred_ghr),
        .upd_ghr         (upd_ghr)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic lookup(input string tag, input logic [31:0] a, input logic hit,
                          input logic tk, input logic [31:0] tgt);
        pc = a;
        #1;
        check({tag, ".hit"},    32'(pred_hit),   32'(hit));
        check({tag, ".taken"},  32'(pred_taken), 32'(tk));
        check({tag, ".target"}, pred_target,     tgt);
    endtask

    // Drive one resolved branch, check mispredict, then clock it in.
    task automatic resolve(input string tag, input logic [31:0] a, input logic tk,
                           input logic [31:0] tgt, input logic ptk,
                           input logic [31:0] ptgt, input logic exp_mp);
        upd_valid = 1'b1; upd_pc = a; upd_taken = tk; upd_target = tgt;
        upd_pred_taken = ptk; upd_pred_target = ptgt;
        #1;
        check({tag, ".mispredict"}, 32'(mispredict), 32'(exp_mp));
        @(posedge clk); #1;
        upd_valid = 1'b0;
    endtask

    localparam logic [31:0] A  = 32'h0040_0010;
    localparam logic [31:0] TA = 32'h0040_0040;
    localparam logic [31:0] B  = 32'h0040_1010;   // same index as A, tag 0x10
    localparam logic [31:0] TB = 32'h0040_1080;
    localparam logic [31:0] TB2 = 32'h0040_10C0;
    localparam logic [31:0] C  = 32'h0040_2020;

    initial begin
        reset = 1'b0; flush = 1'b0; pc = A;
        upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
        upd_pred_taken = 1'b0; upd_pred_target = '0;
        #12;
        // ---- reset state
        lookup("rst", A, 1'b0, 1'b0, 32'h0040_0014);
        check("rst.branch_cnt", branch_cnt, 32'd0);
        check("rst.mispredict_cnt", mispredict_cnt, 32'd0);
        // mispredict is combinational even while in reset
        upd_valid = 1'b1; upd_taken = 1'b1; upd_pred_taken = 1'b0; #1;
        check("rst.mispredict_comb", 32'(mispredict), 32'd1);
        upd_valid = 1'b0; #1;
        check("rst.mispredict_idle", 32'(mispredict), 32'd0);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        check("rst.cnt_held", branch_cnt, 32'd0);

        // ---- first taken: allocate at weakly taken (ctr=2)
        resolve("alloc", A, 1'b1, TA, 1'b0, 32'h0, 1'b1);
        lookup("alloc", A, 1'b1, 1'b1, TA);
        check("alloc.branch_cnt", branch_cnt, 32'd1);
        check("alloc.mispredict_cnt", mispredict_cnt, 32'd1);

        // ---- three more taken (ctr 3,3,3), correctly predicted
        for (int i = 0; i < 3; i++) begin
            resolve("tk", A, 1'b1, TA, 1'b1, TA, 1'b0);
            lookup("tk", A, 1'b1, 1'b1, TA);
        end
        // wrong target only
        upd_valid = 1'b1; upd_pc = A; upd_taken = 1'b1; upd_target = TA;
        upd_pred_taken = 1'b1; upd_pred_target = TB; #1;
        check("tgt.mispredict", 32'(mispredict), 32'd1);
        upd_valid = 1'b0; #1;

        // ---- not-taken walk: 3->2 (taken), 2->1 (not), 1->0 (not)
        resolve("nt1", A, 1'b0, TA, 1'b1, TA, 1'b1);
        lookup("nt1", A, 1'b1, 1'b1, TA);
        resolve("nt2", A, 1'b0, TA, 1'b1, TA, 1'b1);
        lookup("nt2", A, 1'b1, 1'b0, 32'h0040_0014);
        resolve("nt3", A, 1'b0, TA, 1'b0, 32'h0, 1'b0);
        lookup("nt3", A, 1'b1, 1'b0, 32'h0040_0014);
        // 0 must not wrap: one taken brings it to 1, still not taken
        resolve("sat0", A, 1'b1, TA, 1'b0, 32'h0, 1'b1);
        lookup("sat0", A, 1'b1, 1'b0, 32'h0040_0014);
        check("walk.branch_cnt", branch_cnt, 32'd8);
        check("walk.mispredict_cnt", mispredict_cnt, 32'd4);

        // ---- aliasing: B replaces A in the same slot
        resolve("alias", B, 1'b1, TB, 1'b0, 32'h0, 1'b1);
        lookup("alias.A", A, 1'b0, 1'b0, 32'h0040_0014);
        lookup("alias.B", B, 1'b1, 1'b1, TB);

        // ---- same-cycle lookup and update: old contents until the edge
        pc = B;
        upd_valid = 1'b1; upd_pc = B; upd_taken = 1'b1; upd_target = TB2;
        upd_pred_taken = 1'b1; upd_pred_target = TB; #1;
        check("same.mispredict", 32'(mispredict), 32'd1);
        check("same.old_target", pred_target, TB);
        @(posedge clk); #1;
        upd_valid = 1'b0;
        lookup("same.new", B, 1'b1, 1'b1, TB2);

        // ---- flush with update: flush wins, counters still count
        flush = 1'b1;
        resolve("flush", C, 1'b1, TA, 1'b0, 32'h0, 1'b1);
        flush = 1'b0;
        lookup("flush.B", B, 1'b0, 1'b0, 32'h0040_1014);
        lookup("flush.C", C, 1'b0, 1'b0, 32'h0040_2024);
        check("flush.branch_cnt", branch_cnt, 32'd11);
        check("flush.mispredict_cnt", mispredict_cnt, 32'd7);

        // ---- asynchronous reset mid-cycle clears immediately
        resolve("pre_rst", C, 1'b1, TA, 1'b0, 32'h0, 1'b1);
        lookup("pre_rst", C, 1'b1, 1'b1, TA);
        @(negedge clk); #2;
        reset = 1'b0; #1;
        check("arst.branch_cnt", branch_cnt, 32'd0);
        check("arst.mispredict_cnt", mispredict_cnt, 32'd0);
        lookup("arst", C, 1'b0, 1'b0, 32'h0040_2024);
        reset = 1'b1;
        @(posedge clk); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // Hard bound on the run time.
    initial begin
        #20000;
        n_fail++;
        $display("FAIL timeout: observed no end of test, expected finish before 20000");
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $fatal(1, "timeout");
    end

endmodule
